// File: rtl/mux_rr_stream.sv
// mux_rr_stream: selects one of NUM_IN valid/ready input channels onto a
// registered valid/ready output channel. Selection is either fixed (sel) or
// round-robin starting at an internal pointer.
//
// Optional build macro: MUX_RR_STREAM_LOCK_EN adds packet locking via in_last
// and out_last. Once a channel sends a beat without in_last, it keeps the grant
// until its in_last beat.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   in_data       NUM_IN packed channels, channel i at [i*DATA_W +: DATA_W]
//   in_valid      per-channel valid
//   in_ready      per-channel ready (combinational, at most one set)
//   mode          0 = fixed select, 1 = round-robin
//   sel           channel index used in fixed mode
//   in_last       (lock build only) per-channel end-of-packet marker
//   out_data      registered output data
//   out_valid     registered output valid
//   out_ready     downstream ready
//   out_src       index of the channel that supplied out_data
//   out_last      (lock build only) registered end-of-packet marker
module mux_rr_stream #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_IN*DATA_W-1:0] in_data,
    input  logic [NUM_IN-1:0]        in_valid,
    output logic [NUM_IN-1:0]        in_ready,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
`ifdef MUX_RR_STREAM_LOCK_EN
    input  logic [NUM_IN-1:0]        in_last,
    output logic                     out_last,
`endif
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SEL_W-1:0]         out_src
);

    logic [DATA_W-1:0] out_data_q;
    logic              out_valid_q;
    logic [SEL_W-1:0]  out_src_q;
    logic [SEL_W-1:0]  ptr_q;

    logic              load;
    logic              cand_ok;
    logic [SEL_W-1:0]  cand;
    logic [NUM_IN-1:0] grant;
    logic [DATA_W-1:0] sel_data;
    logic              sel_last;
    logic              xfer;
    logic [SEL_W-1:0]  ptr_next;

`ifdef MUX_RR_STREAM_LOCK_EN
    logic              lock_q;
    logic [SEL_W-1:0]  lock_ch_q;
    logic              out_last_q;
`endif

    always_comb begin
        load     = !out_valid_q || out_ready;
        cand     = '0;
        cand_ok  = 1'b0;
        grant    = '0;
        sel_data = '0;
        sel_last = 1'b1;

        if (mode) begin
            // Two-pass wrap search: first channels at or above ptr, then the
            // lowest valid channel, which is necessarily below ptr.
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!cand_ok && in_valid[i] && (SEL_W'(i) >= ptr_q)) begin
                    cand    = SEL_W'(i);
                    cand_ok = 1'b1;
                end
            end
            for (int unsigned i = 0; i < NUM_IN; i++) begin
                if (!cand_ok && in_valid[i]) begin
                    cand    = SEL_W'(i);
                    cand_ok = 1'b1;
                end
            end
        end else begin
            cand    = sel;
            cand_ok = (32'(sel) < NUM_IN);
        end

`ifdef MUX_RR_STREAM_LOCK_EN
        // An open packet owns the output regardless of mode, sel or priority.
        if (lock_q) begin
            cand    = lock_ch_q;
            cand_ok = 1'b1;
        end
`endif

        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (cand_ok && (cand == SEL_W'(i)) && in_valid[i]) begin
                grant[i] = 1'b1;
                sel_data = in_data[i*DATA_W +: DATA_W];
`ifdef MUX_RR_STREAM_LOCK_EN
                sel_last = in_last[i];
`endif
            end
        end

        in_ready = (rst || !load) ? '0 : grant;
        xfer     = |in_ready;
        ptr_next = (cand == SEL_W'(NUM_IN - 1)) ? '0 : cand + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
`ifdef MUX_RR_STREAM_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
            out_last_q  <= 1'b0;
`endif
        end else if (xfer) begin
            out_data_q  <= sel_data;
            out_src_q   <= cand;
            out_valid_q <= 1'b1;
            // sel_last is tied high without locking, so every beat advances.
            if (mode && sel_last) begin
                ptr_q <= ptr_next;
            end
`ifdef MUX_RR_STREAM_LOCK_EN
            out_last_q <= sel_last;
            lock_q     <= !sel_last;
            lock_ch_q  <= cand;
`endif
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;
`ifdef MUX_RR_STREAM_LOCK_EN
    assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_mux_rr_stream.sv
// Bench for mux_rr_stream: table of single-cycle arbitration vectors plus
// hand-written multi-cycle sequences; output beats checked via a scoreboard.
module tb_mux_rr_stream;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned NUM_IN = 4;
    localparam int unsigned SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_IN*DATA_W-1:0] in_data;
    logic [NUM_IN-1:0]        in_valid;
    logic [NUM_IN-1:0]        in_ready;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [DATA_W-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic [SEL_W-1:0]         out_src;
`ifdef MUX_RR_STREAM_LOCK_EN
    logic [NUM_IN-1:0]        in_last;
    logic                     out_last;
`endif

    logic [DATA_W-1:0] chd [NUM_IN];

    always_comb begin
        for (int i = 0; i < NUM_IN; i++) in_data[i*DATA_W +: DATA_W] = chd[i];
    end

    always #5 clk = ~clk;

    mux_rr_stream #(
        .DATA_W(DATA_W),
        .NUM_IN(NUM_IN),
        .SEL_W (SEL_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mode     (mode),
        .sel      (sel),
`ifdef MUX_RR_STREAM_LOCK_EN
        .in_last  (in_last),
        .out_last (out_last),
`endif
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_src  (out_src)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [SEL_W-1:0]  src;
        logic              last;
    } beat_t;

    typedef struct {
        logic              mode;
        logic [SEL_W-1:0]  sel;
        logic [NUM_IN-1:0] valid;
        logic [NUM_IN-1:0] exp_ready;
    } vec_t;

    beat_t sb[$];
    vec_t  vt[10];
    int    checks   = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Record the beat the DUT should emit for a grant given as a one-hot.
    task automatic expect_grant(input logic [NUM_IN-1:0] exp_ready);
        beat_t b;
        for (int i = 0; i < NUM_IN; i++) begin
            if (exp_ready[i]) begin
                b.data = chd[i];
                b.src  = SEL_W'(i);
`ifdef MUX_RR_STREAM_LOCK_EN
                b.last = in_last[i];
`else
                b.last = 1'b0;
`endif
                sb.push_back(b);
            end
        end
    endtask

    // One clock: check in_ready mid-cycle, log the expected beat, advance.
    task automatic cyc(input string name, input logic [NUM_IN-1:0] exp_ready);
        @(negedge clk);
        check(name, in_ready, exp_ready);
        expect_grant(exp_ready);
        @(posedge clk);
        #1;
    endtask

    // Output monitor: every completed output transfer pops one expected beat.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat: got src %0d data %0h, expected no beat",
                         out_src, out_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_data", out_data, e.data);
                check("beat_src", out_src, e.src);
`ifdef MUX_RR_STREAM_LOCK_EN
                check("beat_last", out_last, e.last);
`endif
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_IN; i++) chd[i] = DATA_W'(32'h10 + i);
        chd[2] = 32'hDEADBEEF;

        // mode, sel, valid, expected in_ready; ptr starts at 0
        vt[0] = '{1'b0, 2'd2, 4'b0101, 4'b0100};
        vt[1] = '{1'b0, 2'd3, 4'b0111, 4'b0000};
        vt[2] = '{1'b0, 2'd0, 4'b0001, 4'b0001};
        vt[3] = '{1'b0, 2'd1, 4'b0000, 4'b0000};
        vt[4] = '{1'b1, 2'd0, 4'b1111, 4'b0001};  // ptr -> 1
        vt[5] = '{1'b1, 2'd0, 4'b1001, 4'b1000};  // wraps past ch1/ch2, ptr -> 0
        vt[6] = '{1'b1, 2'd0, 4'b0110, 4'b0010};  // ptr -> 2
        vt[7] = '{1'b1, 2'd0, 4'b0000, 4'b0000};
        vt[8] = '{1'b0, 2'd3, 4'b1000, 4'b1000};  // fixed mode, ptr stays 2
        vt[9] = '{1'b1, 2'd0, 4'b1011, 4'b1000};  // from ptr 2 -> ch3, ptr -> 0

        // Reset with inputs valid: nothing may be accepted.
        rst       = 1'b1;
        in_valid  = '1;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b1;
`ifdef MUX_RR_STREAM_LOCK_EN
        in_last   = '0;
`endif
        cyc("rst_in_ready", '0);
        cyc("rst_in_ready", '0);
        rst      = 1'b0;
        in_valid = '0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_src", out_src, 0);
        cyc("idle_in_ready", '0);
        check("idle_out_valid", out_valid, 0);

        for (int v = 0; v < 10; v++) begin
            mode     = vt[v].mode;
            sel      = vt[v].sel;
            in_valid = vt[v].valid;
            cyc($sformatf("vec%0d_in_ready", v), vt[v].exp_ready);
        end
        in_valid = '0;
        cyc("vec_drain", '0);

        // Round-robin fairness, all valid, one beat per cycle (ptr = 0).
        chd[2]   = 32'h12;
        mode     = 1'b1;
        in_valid = '1;
        for (int k = 0; k < 6; k++) begin
            logic [NUM_IN-1:0] exp_r;
            exp_r = NUM_IN'(1) << (k % NUM_IN);
            @(negedge clk);
            check($sformatf("rr%0d_in_ready", k), in_ready, exp_r);
            if (k > 0) check($sformatf("rr%0d_no_bubble", k), out_valid, 1);
            expect_grant(exp_r);
            @(posedge clk);
            #1;
        end
        // ptr = 2: grant ch2 -> ptr 3; ch3 next -> ptr 0; then ch1.
        in_valid = 4'b0100;
        cyc("wrap_ch2", 4'b0100);
        in_valid = 4'b1010;
        cyc("wrap_ch3", 4'b1000);
        cyc("wrap_ch1", 4'b0010);
        in_valid = '0;
        cyc("wrap_drain", '0);

        // Backpressure: hold A5A5A5A5 for 5 cycles with everything valid.
        chd[0]    = 32'hA5A5A5A5;
        mode      = 1'b0;
        sel       = '0;
        out_ready = 1'b0;
        in_valid  = 4'b0001;
        cyc("bp_load", 4'b0001);
        in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
            check("bp_out_data", out_data, 32'hA5A5A5A5);
            check("bp_out_src", out_src, 0);
            @(posedge clk);
            #1;
        end
        // Release: ptr is still 2 (fixed mode leaves it), new beat loads at once.
        chd[0]    = 32'h10;
        out_ready = 1'b1;
        mode      = 1'b1;
        cyc("bp_release", 4'b0100);
        check("bp_reload_valid", out_valid, 1);
        check("bp_reload_src", out_src, 2);

        // Mid-stream reset discards the held ch2 beat and returns ptr to 0.
        out_ready = 1'b0;
        in_valid  = '0;
        cyc("hold_beat", '0);
        rst = 1'b1;
        void'(sb.pop_back());
        cyc("mid_rst_in_ready", '0);
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        out_ready = 1'b1;
        in_valid  = '1;
        cyc("mid_rst_ptr0", 4'b0001);
        in_valid = '0;
        cyc("mid_rst_drain", '0);

`ifdef MUX_RR_STREAM_LOCK_EN
        rst = 1'b1;
        cyc("lock_rst", '0);
        rst      = 1'b0;
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_last  = 4'b0000;
        cyc("lock_b0", 4'b0001);
        mode = 1'b0;
        sel  = 2'd1;
        cyc("lock_b1_overrides_sel", 4'b0001);
        mode    = 1'b1;
        in_last = 4'b0001;
        cyc("lock_b2_last", 4'b0001);
        in_valid = 4'b0010;
        in_last  = 4'b0010;
        cyc("lock_release_ch1", 4'b0010);
        in_valid = '0;
        in_last  = '0;
        cyc("lock_drain", '0);
`endif

        cyc("final_drain", '0);
        cyc("final_drain", '0);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
